// File: rtl/pilha_pkg.sv
// rtl/pilha_pkg.sv - shared state encoding and op constants for the stack controller
package pilha_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/pilha_ptr_calc.sv
// rtl/pilha_ptr_calc.sv - next stack pointer and memory word address selection
module pilha_ptr_calc
  import pilha_pkg::*;
(
  input  logic [31:0] sp,
  input  logic        wr_phase,
  input  logic        rd_phase,
  input  logic        dec_phase,
  output logic [31:0] sp_next,
  output logic [31:0] addr
);

  logic [31:0] sp_inc;
  logic [31:0] sp_dec;

  assign sp_inc = sp + 32'd1;
  assign sp_dec = sp - 32'd1;

  always_comb begin
    sp_next = sp;
    addr    = 32'd0;
    if (wr_phase) begin
      sp_next = sp_inc;
      addr    = sp_inc;
    end else if (rd_phase) begin
      addr    = sp;
    end else if (dec_phase) begin
      sp_next = sp_dec;
    end
  end

endmodule

// File: rtl/pilha_ctrl.sv
// rtl/pilha_ctrl.sv - push/pop stack controller in front of a word-addressed memory
module pilha_ctrl
  import pilha_pkg::*;
#(
  parameter logic [31:0] SP_BASE = 32'd0,
  parameter logic [31:0] DEPTH   = 32'd256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_data,
  output logic        req_ready,
  input  logic        clear,
  output logic        done,
  output logic        err,
  output logic [31:0] pop_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [31:0] sp,
  output logic        full,
  output logic        empty
);

  state_t      state;
  state_t      state_next;
  logic        op_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        err_next;
  logic        accept;
  logic [31:0] sp_next;
  logic        wr_phase;
  logic        rd_phase;
  logic        dec_phase;

  assign full      = (sp == SP_BASE + DEPTH);
  assign empty     = (sp == SP_BASE);
  assign req_ready = (state == IDLE) && !clear;
  assign accept    = req_valid && req_ready;

  assign wr_phase  = (state == WRITE) && (op_q == OP_PUSH);
  assign rd_phase  = (state == READ)  && (op_q == OP_POP);
  assign dec_phase = (state == WAIT)  && (op_q == OP_POP);

  pilha_ptr_calc u_ptr_calc (
    .sp        (sp),
    .wr_phase  (wr_phase),
    .rd_phase  (rd_phase),
    .dec_phase (dec_phase),
    .sp_next   (sp_next),
    .addr      (mem_addr)
  );

  // Strobes are pure state decodes, so reset/clear returning to IDLE kills them at once
  assign mem_we    = wr_phase;
  assign mem_re    = rd_phase;
  assign mem_wdata = wr_phase ? data_q : 32'd0;
  assign done      = (state == RESP);
  assign err       = (state == RESP) && err_q;

  always_comb begin
    state_next = state;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_op == OP_PUSH) begin
            err_next   = full;
            state_next = full ? RESP : WRITE;
          end else begin
            err_next   = empty;
            state_next = empty ? RESP : READ;
          end
        end
      end
      WRITE:   state_next = RESP;
      READ:    state_next = WAIT;
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      sp       <= SP_BASE;
      pop_data <= 32'd0;
      op_q     <= OP_POP;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      sp    <= SP_BASE;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      sp    <= sp_next;
      err_q <= err_next;
      if (accept) begin
        op_q   <= req_op;
        data_q <= req_data;
      end
      if (dec_phase) begin
        pop_data <= mem_rdata;
      end
    end
  end

endmodule
